// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock through a single
// full-subtractor cell, with a start/busy/done handshake.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] rd_next;

  // Full-subtractor cell on the operand LSBs; result bits enter rd from the top.
  always_comb begin
    d       = ra[0] ^ rb[0] ^ br;
    br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    rd_next = '0;
    rd_next[WIDTH-1] = d;
    for (int i = 0; i < WIDTH - 1; i++) begin
      rd_next[i] = rd[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= rd_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // The last bit goes straight into the output registers, so diff
          // never exposes a partially shifted result.
          if (cnt == LAST) begin
            diff  <= rd_next;
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: a scoreboard queue fed on every accepting
// edge and drained on every done pulse, plus directed timing and reset checks.
module tb_serial_sub4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int busyCnt    = 0;
  logic prevDone = 1'b0;
  logic [4:0] sbq[$];

  serial_sub4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: an accept happens when start is seen in IDLE (busy and done low).
  always @(posedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (start && !busy && !done) begin
      sbq.push_back({1'b0, a} - {1'b0, b} - {4'b0, bin});
    end
  end

  // Output monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (busy) busyCnt++;
    else if (!done) busyCnt = 0;
    if (done) begin
      checkOutput("busyAtDone", {31'b0, busy}, 32'd0);
      checkOutput("doneTwice", {31'b0, prevDone}, 32'd0);
      checkOutput("busyCycles", busyCnt, 32'd4);
      if (sbq.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        checkOutput("result", {27'b0, bout, diff}, {27'b0, sbq.pop_front()});
      end
    end
    prevDone = done;
  end

  task automatic waitDone(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneTimeout", {31'b0, done}, 32'd1);
    c = cyc;
  endtask

  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    logic idleNow;
    int   n;
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    n     = 0;
    idleNow = !busy && !done;
    @(posedge clk);
    while (!idleNow && n < 20) begin
      @(negedge clk);
      idleNow = !busy && !done;
      @(posedge clk);
      n++;
    end
    checkOutput("acceptTimeout", {31'b0, idleNow}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneLatency", n, 32'd5);
  endtask

  initial begin
    int c0, c1, c2, c3;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;

    // Reset behaviour
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstDiff", {28'b0, diff}, 32'd0);
    checkOutput("rstBout", {31'b0, bout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and underflow cases
    applyStimulus(4'b0110, 4'b0011, 1'b0);
    checkOutput("basic1", {27'b0, bout, diff}, {27'b0, 5'b0_0011});
    applyStimulus(4'b1010, 4'b0101, 1'b1);
    checkOutput("basic2", {27'b0, bout, diff}, {27'b0, 5'b0_0100});
    applyStimulus(4'b0011, 4'b0110, 1'b0);
    checkOutput("under1", {27'b0, bout, diff}, {27'b0, 5'b1_1101});
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("under2", {27'b0, bout, diff}, {27'b0, 5'b1_1111});
    repeat (3) @(negedge clk);
    checkOutput("diffHeld", {27'b0, bout, diff}, {27'b0, 5'b1_1111});

    // Back-to-back with start held high, operands changed mid-SHIFT
    a     = 4'b1111;
    b     = 4'b1111;
    bin   = 1'b0;
    start = 1'b1;
    waitDone(c0);
    checkOutput("b2b0", {27'b0, bout, diff}, 32'd0);
    waitDone(c1);
    checkOutput("b2bGap1", c1 - c0, 32'd6);
    checkOutput("b2b1", {27'b0, bout, diff}, 32'd0);
    repeat (3) @(negedge clk);
    a   = 4'b1001;
    b   = 4'b0110;
    bin = 1'b1;
    waitDone(c2);
    checkOutput("b2bGap2", c2 - c1, 32'd6);
    checkOutput("b2b2", {27'b0, bout, diff}, 32'd0);
    waitDone(c3);
    start = 1'b0;
    checkOutput("b2bGap3", c3 - c2, 32'd6);
    checkOutput("b2b3", {27'b0, bout, diff}, {27'b0, 5'b0_0010});
    repeat (3) @(negedge clk);

    // Reset on the second SHIFT edge aborts the operation
    a     = 4'b1100;
    b     = 4'b0011;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("abortBusyPre", {31'b0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", {31'b0, busy}, 32'd0);
    checkOutput("abortDone", {31'b0, done}, 32'd0);
    checkOutput("abortDiff", {28'b0, diff}, 32'd0);
    checkOutput("abortBout", {31'b0, bout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abortNoDone", {31'b0, done}, 32'd0);
    end
    applyStimulus(4'b1100, 4'b0011, 1'b0);
    checkOutput("afterAbort", {27'b0, bout, diff}, {27'b0, 5'b0_1001});

    // Exhaustive sweep, checked by the scoreboard monitor
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          applyStimulus(4'(ai), 4'(bi), 1'(ci));
        end
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("sbEmpty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
